ram_2r2w_bist: RTL

RAM_2R2W_BIST -- requirements
Module: ram_2r2w_bist

---
 rtl/ram_2r2w_bist.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ram_2r2w_bist.sv
// March-style BIST for a two-read/two-write RAM: writes P then ~P across all words,
// reading each word back through the opposite port and counting miscompares.
module ram_2r2w_bist #(
  parameter int unsigned BLOCKSIZE = 10,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [BLOCKSIZE:0] w1_addr,
  output logic [BLOCKSIZE:0] w2_addr,
  output logic [31:0]        w1_din,
  output logic [31:0]        w2_din,
  output logic               en_w1,
  output logic               en_w2,
  output logic [BLOCKSIZE:0] r1_addr,
  output logic [BLOCKSIZE:0] r2_addr,
  input  logic [31:0]        d1,
  input  logic [31:0]        d2,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_cnt,
  output logic [BLOCKSIZE:0] fail_addr
);

  localparam int AW     = BLOCKSIZE + 1;
  localparam int CW     = 3 * AW;
  // Width of the trailing copy of the address once {a, ~a, a} is fitted into 32 bits
  localparam int LOWW   = (CW <= 32) ? AW : ((2 * AW < 32) ? 32 - 2 * AW : 0);
  localparam int PREOFF = (2 * AW > 32) ? 2 * AW - 32 : 0;
  localparam logic [31:0] LOWMASK = 32'((64'd1 << LOWW) - 64'd1);

  function automatic logic [31:0] pattern(input logic [AW-1:0] a);
    logic [63:0] pre;
    logic [31:0] ax;
    pre = 64'({a, ~a});
    ax  = 32'(a);
    return 32'((pre << LOWW) >> PREOFF) | (ax & LOWMASK);
  endfunction

  typedef enum logic [2:0] {StIdle, StW0, StR0, StW1, StR1, StDone} state_e;

  state_e               state_q, state_d;
  logic [BLOCKSIZE-1:0] k_q, k_d;
  logic [2:0]           drn_q, drn_d;
  logic [15:0]          err_q, err_d;
  logic [AW-1:0]        fail_q, fail_d;

  logic                 pv_q  [READ_LAT];
  logic [31:0]          pe1_q [READ_LAT];
  logic [31:0]          pe2_q [READ_LAT];
  logic [AW-1:0]        pa1_q [READ_LAT];
  logic [AW-1:0]        pa2_q [READ_LAT];

  logic [AW-1:0] a_even, a_odd;
  logic [31:0]   pat_even, pat_odd;
  logic          in_w, in_r, issue, inv, m1, m2;
  logic [16:0]   sum;

  assign a_even   = {k_q, 1'b0};
  assign a_odd    = {k_q, 1'b1};
  assign in_w     = (state_q == StW0) || (state_q == StW1);
  assign in_r     = (state_q == StR0) || (state_q == StR1);
  assign issue    = in_r && (drn_q == 3'd0);
  assign inv      = (state_q == StW1) || (state_q == StR1);
  assign pat_even = pattern(a_even) ^ {32{inv}};
  assign pat_odd  = pattern(a_odd) ^ {32{inv}};

  assign m1  = pv_q[READ_LAT-1] && (d1 != pe1_q[READ_LAT-1]);
  assign m2  = pv_q[READ_LAT-1] && (d2 != pe2_q[READ_LAT-1]);
  assign sum = {1'b0, err_q} + {16'd0, m1} + {16'd0, m2};

  always_comb begin
    en_w1   = 1'b0;
    en_w2   = 1'b0;
    w1_addr = '0;
    w2_addr = '0;
    w1_din  = '0;
    w2_din  = '0;
    r1_addr = '0;
    r2_addr = '0;
    if (in_w) begin
      en_w1   = 1'b1;
      en_w2   = 1'b1;
      w1_addr = a_even;
      w1_din  = pat_even;
      w2_addr = a_odd;
      w2_din  = pat_odd;
    end
    // Cross-port read: port 1 checks what port 2 wrote and vice versa
    if (issue) begin
      r1_addr = a_odd;
      r2_addr = a_even;
    end
    busy      = in_w || in_r;
    done      = (state_q == StDone);
    pass      = done && (err_q == 16'd0);
    err_cnt   = err_q;
    fail_addr = fail_q;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drn_d   = drn_q;
    err_d   = sum[16] ? 16'hFFFF : sum[15:0];
    fail_d  = fail_q;
    if ((m1 || m2) && (err_q == 16'd0)) begin
      fail_d = m1 ? pa1_q[READ_LAT-1] : pa2_q[READ_LAT-1];
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StW0;
          k_d     = '0;
          drn_d   = 3'd0;
          err_d   = 16'd0;
          fail_d  = '0;
        end
      end
      StW0, StW1: begin
        k_d = k_q + 1'b1;
        if (&k_q) begin
          state_d = (state_q == StW0) ? StR0 : StR1;
        end
      end
      StR0, StR1: begin
        if (drn_q == 3'd0) begin
          k_d = k_q + 1'b1;
          if (&k_q) begin
            drn_d = 3'd1;
          end
        end else if (drn_q == 3'(READ_LAT)) begin
          drn_d   = 3'd0;
          state_d = (state_q == StR0) ? StW1 : StDone;
        end else begin
          drn_d = drn_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      drn_q   <= 3'd0;
      err_q   <= 16'd0;
      fail_q  <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i]  <= 1'b0;
        pe1_q[i] <= '0;
        pe2_q[i] <= '0;
        pa1_q[i] <= '0;
        pa2_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      drn_q    <= drn_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      pv_q[0]  <= issue;
      pe1_q[0] <= pat_odd;
      pe2_q[0] <= pat_even;
      pa1_q[0] <= a_odd;
      pa2_q[0] <= a_even;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pe1_q[i] <= pe1_q[i-1];
        pe2_q[i] <= pe2_q[i-1];
        pa1_q[i] <= pa1_q[i-1];
        pa2_q[i] <= pa2_q[i-1];
      end
    end
  end

endmodule
